// File: rtl/dram_byte_reader_if.sv
// Signal bundle between the byte reader, its requester/consumer and the 8-lane DRAM port.
// The slave modport is the reader's view; master is the environment's view.
interface dram_byte_reader_if;
   logic             req_valid;
   logic             req_ready;
   logic [63:0]      req_addr;
   logic [7:0]       req_len;

   logic             out_valid;
   logic             out_ready;
   logic [7:0]       out_data;
   logic             out_last;
   logic             error;

   logic [7:0]       dram_en;
   logic             dram_rdwr;
   logic [7:0][63:0] dram_addr;
   logic [7:0][7:0]  dram_data_in;
   logic [7:0][7:0]  dram_data_out;
   logic [7:0]       dram_valid;

   modport slave (
      input  req_valid, req_addr, req_len, out_ready, dram_data_out, dram_valid,
      output req_ready, out_valid, out_data, out_last, error,
             dram_en, dram_rdwr, dram_addr, dram_data_in
   );

   modport master (
      output req_valid, req_addr, req_len, out_ready, dram_data_out, dram_valid,
      input  req_ready, out_valid, out_data, out_last, error,
             dram_en, dram_rdwr, dram_addr, dram_data_in
   );
endinterface

// File: rtl/dram_byte_reader.sv
// Reads a byte range from an 8-lane DRAM in batches of up to 8 bytes and streams
// the bytes out in ascending address order; abandons a request if a batch stalls.
module dram_byte_reader #(
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              reset,
   dram_byte_reader_if.slave bus
);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;

   state_t           state_reg, state_next;
   logic [63:0]      cur_addr_reg, cur_addr_next;
   logic [7:0]       remaining_reg, remaining_next;
   logic [3:0]       cnt_reg, cnt_next;
   logic [2:0]       idx_reg, idx_next;
   logic [7:0]       got_reg, got_next;
   logic [TW-1:0]    timer_reg, timer_next;
   logic             error_reg, error_next;
   logic [7:0]       byte_buf_reg [8];

   logic [3:0]       issue_cnt;
   logic [7:0]       issue_mask;
   logic [7:0]       wait_mask;
   logic [7:0]       capture;
   logic [7:0][63:0] lane_addr;
   logic             got_complete;
   logic [2:0]       last_idx;
   logic             last_batch;

   assign issue_cnt    = (remaining_reg >= 8'd8) ? 4'd8 : remaining_reg[3:0];
   assign last_idx     = 3'(cnt_reg - 4'd1);
   assign last_batch   = (remaining_reg == {4'd0, cnt_reg});
   // A valid arriving in the completing cycle already counts towards completion.
   assign got_complete = ((got_reg | capture) & wait_mask) == wait_mask;

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_lane
         assign issue_mask[gi] = (4'(gi) < issue_cnt);
         assign wait_mask[gi]  = (4'(gi) < cnt_reg);
         assign capture[gi]    = (state_reg == WAIT) && bus.dram_valid[gi] && wait_mask[gi];
         assign lane_addr[gi]  = cur_addr_reg + 64'(gi);
      end
   endgenerate

   assign bus.dram_data_in = '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         cur_addr_reg  <= '0;
         remaining_reg <= '0;
         cnt_reg       <= '0;
         idx_reg       <= '0;
         got_reg       <= '0;
         timer_reg     <= '0;
         error_reg     <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cur_addr_reg  <= cur_addr_next;
         remaining_reg <= remaining_next;
         cnt_reg       <= cnt_next;
         idx_reg       <= idx_next;
         got_reg       <= got_next;
         timer_reg     <= timer_next;
         error_reg     <= error_next;
      end
   end

   // Repeated valids on a captured lane simply overwrite; last one wins.
   always_ff @(posedge clk) begin
      for (int k = 0; k < 8; k++) begin
         if (reset) begin
            byte_buf_reg[k] <= '0;
         end else if (capture[k]) begin
            byte_buf_reg[k] <= bus.dram_data_out[k];
         end
      end
   end

   always_comb begin
      state_next     = state_reg;
      cur_addr_next  = cur_addr_reg;
      remaining_next = remaining_reg;
      cnt_next       = cnt_reg;
      idx_next       = idx_reg;
      got_next       = got_reg;
      timer_next     = timer_reg;
      error_next     = 1'b0;

      case (state_reg)
         IDLE: begin
            if (bus.req_valid) begin
               cur_addr_next  = bus.req_addr;
               remaining_next = bus.req_len;
               if (bus.req_len != 8'd0) begin
                  state_next = ISSUE;
               end
            end
         end
         ISSUE: begin
            cnt_next   = issue_cnt;
            got_next   = '0;
            timer_next = '0;
            idx_next   = '0;
            state_next = WAIT;
         end
         WAIT: begin
            got_next   = got_reg | capture;
            timer_next = timer_reg + 1'b1;
            if (got_complete) begin
               idx_next   = '0;
               state_next = DRAIN;
            end else if (timer_reg == TW'(TIMEOUT - 1)) begin
               // The whole request is dropped, not just this batch.
               error_next     = 1'b1;
               remaining_next = '0;
               state_next     = IDLE;
            end
         end
         DRAIN: begin
            if (bus.out_ready) begin
               idx_next = idx_reg + 1'b1;
               if (idx_reg == last_idx) begin
                  remaining_next = remaining_reg - {4'd0, cnt_reg};
                  cur_addr_next  = cur_addr_reg + 64'(cnt_reg);
                  state_next     = last_batch ? IDLE : ISSUE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Every output is forced low while reset is held, including the DRAM direction.
   always_comb begin
      bus.req_ready = 1'b0;
      bus.out_valid = 1'b0;
      bus.out_data  = '0;
      bus.out_last  = 1'b0;
      bus.error     = 1'b0;
      bus.dram_en   = '0;
      bus.dram_rdwr = 1'b0;
      bus.dram_addr = '0;
      if (!reset) begin
         bus.dram_rdwr = 1'b1;
         bus.error     = error_reg;
         case (state_reg)
            IDLE:  bus.req_ready = 1'b1;
            ISSUE: begin
               bus.dram_en   = issue_mask;
               bus.dram_addr = lane_addr;
            end
            DRAIN: begin
               bus.out_valid = 1'b1;
               bus.out_data  = byte_buf_reg[idx_reg];
               bus.out_last  = (idx_reg == last_idx) && last_batch;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_dram_byte_reader.sv
// Randomized bench for dram_byte_reader: a lane-level DRAM responder plus a
// request-level model of expected DRAM batches, output bytes and timeout pulses.
module tb_dram_byte_reader;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   dram_byte_reader_if bus();

   dram_byte_reader #(.TIMEOUT(64)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {logic [63:0] base; logic [7:0] mask;} issue_t;
   typedef struct packed {logic [7:0] data; logic last;} byte_t;

   issue_t exp_issue[$];
   byte_t  exp_bytes[$];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int n_issues = 0;
   int exp_err_cyc   = -1;
   int accept_cyc    = 0;
   int first_out_cyc = -1;
   bit first_pending = 0;

   int drop_lane  = -1;
   bit hold_resp  = 0;
   bit noise      = 0;
   bit ready_rand = 0;
   int max_delay  = 0;
   int force_dly [8];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] mem_byte(input logic [63:0] a);
      logic [63:0] h;
      h = a * 64'h9E37_79B9_7F4A_7C15;
      return h[63:56] ^ a[7:0];
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Model: a request of len bytes at addr is split into ceil(len/8) batches of
   // min(8, left) consecutive addresses; bytes come out in address order.
   task automatic push_model(input logic [63:0] a, input logic [7:0] l);
      issue_t ei;
      byte_t  eb;
      for (int i = 0; i < int'(l); i += 8) begin
         int c;
         c = (int'(l) - i >= 8) ? 8 : int'(l) - i;
         ei.base = a + 64'(i);
         ei.mask = 8'((16'd1 << c) - 16'd1);
         exp_issue.push_back(ei);
      end
      for (int i = 0; i < int'(l); i++) begin
         eb.data = mem_byte(a + 64'(i));
         eb.last = (i == int'(l) - 1);
         exp_bytes.push_back(eb);
      end
   endtask

   task automatic do_req(input logic [63:0] a, input logic [7:0] l);
      int n;
      n = 0;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_addr  = a;
      bus.req_len   = l;
      while (!bus.req_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) check("req_accept_bound", 0, 1);
      $display("[TB] req addr=%016h len=%0d", a, l);
      push_model(a, l);
      accept_cyc    = cyc;
      first_out_cyc = -1;
      first_pending = 1;
      @(negedge clk);
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (!(exp_bytes.size() == 0 && exp_issue.size() == 0 && bus.req_ready) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) check("idle_bound", 0, 1);
   endtask

   // DRAM responder, consumer and output monitor share one negedge process.
   initial begin : monitor
      bit          pend [8];
      bit          ans  [8];
      int          dly  [8];
      logic [63:0] paddr [8];
      logic [7:0]  batch_mask;
      bit          prev_stall;
      logic [7:0]  prev_data;
      logic        prev_last;
      bit          rdy;
      issue_t      ei;
      byte_t       eb;
      batch_mask = '0;
      prev_stall = 0;
      prev_data  = '0;
      prev_last  = 1'b0;
      for (int k = 0; k < 8; k++) begin
         pend[k] = 0; ans[k] = 0; dly[k] = 0; paddr[k] = '0;
      end
      bus.dram_valid    = '0;
      bus.dram_data_out = '0;
      bus.out_ready     = 1'b1;
      forever begin
         @(negedge clk);
         // responder drive for the coming edge, based on previously issued lanes
         for (int k = 0; k < 8; k++) begin
            bus.dram_valid[k]    = 1'b0;
            bus.dram_data_out[k] = 8'($urandom);
            if (pend[k]) begin
               if (!hold_resp) begin
                  if (dly[k] == 0) begin
                     pend[k] = 0;
                     if (k != drop_lane) begin
                        bus.dram_valid[k]    = 1'b1;
                        bus.dram_data_out[k] = mem_byte(paddr[k]);
                        ans[k] = 1;
                     end
                  end else begin
                     dly[k]--;
                  end
               end
            end else if (noise && $urandom_range(0, 3) == 0) begin
               if (!batch_mask[k]) begin
                  bus.dram_valid[k] = 1'b1;
               end else if (ans[k]) begin
                  bus.dram_valid[k]    = 1'b1;
                  bus.dram_data_out[k] = mem_byte(paddr[k]);
               end
            end
         end

         if (bus.dram_en != 8'd0) begin
            n_issues++;
            if (exp_issue.size() == 0) begin
               check("issue_unexpected", 64'(bus.dram_en), 0);
            end else begin
               ei = exp_issue.pop_front();
               check("issue_en", 64'(bus.dram_en), 64'(ei.mask));
               check("issue_rdwr", 64'(bus.dram_rdwr), 1);
               for (int k = 0; k < 8; k++)
                  if (ei.mask[k]) check("issue_addr", bus.dram_addr[k], ei.base + 64'(k));
            end
            batch_mask = bus.dram_en;
            for (int k = 0; k < 8; k++) begin
               pend[k]  = bus.dram_en[k];
               ans[k]   = 0;
               paddr[k] = bus.dram_addr[k];
               dly[k]   = (force_dly[k] >= 0) ? force_dly[k] : $urandom_range(0, max_delay);
            end
            if (drop_lane >= 0 && bus.dram_en[drop_lane]) exp_err_cyc = cyc + 65;
         end

         if (bus.error || cyc == exp_err_cyc) begin
            check("error_pulse", 64'(bus.error), 64'(cyc == exp_err_cyc));
            if (bus.error && cyc == exp_err_cyc) begin
               check("error_ready", 64'(bus.req_ready), 1);
               exp_bytes.delete();
               exp_issue.delete();
            end
            exp_err_cyc = -1;
         end

         if (prev_stall) begin
            check("stall_valid", 64'(bus.out_valid), 1);
            check("stall_data", 64'(bus.out_data), 64'(prev_data));
            check("stall_last", 64'(bus.out_last), 64'(prev_last));
         end
         rdy = ready_rand ? bit'($urandom_range(0, 1)) : 1'b1;
         bus.out_ready = rdy;
         if (bus.out_valid) begin
            if (first_pending) begin
               first_out_cyc = cyc;
               first_pending = 0;
            end
            if (exp_bytes.size() == 0) begin
               check("out_spurious", 64'(bus.out_valid), 0);
            end else if (rdy) begin
               eb = exp_bytes.pop_front();
               check("out_data", 64'(bus.out_data), 64'(eb.data));
               check("out_last", 64'(bus.out_last), 64'(eb.last));
            end
         end
         prev_stall = bus.out_valid && !rdy && !reset;
         prev_data  = bus.out_data;
         prev_last  = bus.out_last;
      end
   end

   initial begin : stimulus
      int n;
      logic [63:0] a;
      logic [7:0]  l;
      for (int k = 0; k < 8; k++) force_dly[k] = -1;
      reset         = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_addr  = '0;
      bus.req_len   = '0;
      repeat (3) @(negedge clk);
      check("rst_req_ready", 64'(bus.req_ready), 0);
      check("rst_dram_rdwr", 64'(bus.dram_rdwr), 0);
      check("rst_dram_en", 64'(bus.dram_en), 0);
      check("rst_dram_addr0", bus.dram_addr[0], 0);
      check("rst_out_valid", 64'(bus.out_valid), 0);
      check("rst_out_last", 64'(bus.out_last), 0);
      check("rst_error", 64'(bus.error), 0);
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_ready", 64'(bus.req_ready), 1);
      check("post_rst_rdwr", 64'(bus.dram_rdwr), 1);

      // single byte, DRAM answers immediately: minimum latency
      max_delay = 0;
      do_req(64'd0, 8'd1);
      wait_idle(2000);
      check("min_latency", 64'(first_out_cyc - accept_cyc), 3);

      // lane 1 answers well before lane 0
      force_dly[0] = 3;
      force_dly[1] = 0;
      do_req(64'd1, 8'd2);
      wait_idle(2000);
      force_dly[0] = -1;
      force_dly[1] = -1;

      max_delay = 4;
      do_req(64'd100, 8'd19);
      wait_idle(2000);
      do_req(64'hFFFF_FFFF_FFFF_FFFE, 8'd4);
      wait_idle(2000);

      // zero-length request: no DRAM or output activity, stays ready
      do_req(64'd500, 8'd0);
      repeat (4) @(negedge clk);
      check("len0_ready", 64'(bus.req_ready), 1);

      ready_rand = 1;
      do_req(64'h1234, 8'd30);
      wait_idle(3000);

      // lane 3 never answers
      drop_lane = 3;
      do_req(64'h8000, 8'd8);
      wait_idle(2000);
      drop_lane = -1;

      // reset while waiting for DRAM, then late valids must be ignored
      hold_resp = 1;
      n = n_issues;
      do_req(64'h4000, 8'd4);
      while (n_issues == n && exp_issue.size() != 0) @(negedge clk);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("midrst_req_ready", 64'(bus.req_ready), 0);
      check("midrst_rdwr", 64'(bus.dram_rdwr), 0);
      check("midrst_out_valid", 64'(bus.out_valid), 0);
      exp_bytes.delete();
      exp_issue.delete();
      reset     = 1'b0;
      hold_resp = 0;
      repeat (10) @(negedge clk);
      check("midrst_idle_ready", 64'(bus.req_ready), 1);
      do_req(64'h4444, 8'd1);
      wait_idle(2000);

      noise = 1;
      for (int t = 0; t < 20; t++) begin
         a = {32'($urandom), 32'($urandom)};
         if ($urandom_range(0, 4) == 0) a = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
         l = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 40));
         max_delay = $urandom_range(0, 6);
         do_req(a, l);
         wait_idle(8000);
      end

      repeat (5) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
      $finish;
   end
endmodule
